// File: rtl/lcd2vga_pkg.sv
// Shared definitions for the LCD->VGA bridge.
//   lock_state_t : lock FSM encoding, also driven on the status port
//   ivl_class_t  : classification of a sync-rise interval
//   VGA_*        : 640x480@60 timing, shared with the VGA timing generator
package lcd2vga_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2,
        ST_HOLD   = 2'd3
    } lock_state_t;

    typedef enum logic [1:0] {
        CLS_BAD  = 2'd0,
        CLS_LINE = 2'd1,
        CLS_GAP  = 2'd2
    } ivl_class_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = 800;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = 525;

endpackage

// File: rtl/sync_interval_meter.sv
// Measures the interval between rising edges of the LCD sync and classifies it.
//   iw_clk      : LCD pixel clock
//   iw_rst_n    : asynchronous active-low reset
//   iw_sync     : LCD composite sync, synchronous to iw_clk
//   ow_rise     : combinational, high in the cycle a sync rise is seen
//   ow_interval : saturating count of clocks since the previous rise (valid with ow_rise)
//   ow_class    : GAP / LINE / BAD classification of ow_interval
//   ow_timeout  : interval counter sits at TIMEOUT and no rise this cycle
module sync_interval_meter
    import lcd2vga_pkg::*;
#(
    parameter int unsigned CW          = 20,
    parameter int unsigned LINE_PERIOD = 800,
    parameter int unsigned LINE_TOL    = 4,
    parameter int unsigned GAP_MIN     = 1000,
    parameter int unsigned TIMEOUT     = 1048575
)(
    input  logic          iw_clk,
    input  logic          iw_rst_n,
    input  logic          iw_sync,
    output logic          ow_rise,
    output logic [CW-1:0] ow_interval,
    output ivl_class_t    ow_class,
    output logic          ow_timeout
);

    localparam logic [CW-1:0] ICNT_MAX = '1;
    localparam int unsigned   LINE_LO  = (LINE_PERIOD > LINE_TOL) ? LINE_PERIOD - LINE_TOL : 0;
    localparam int unsigned   LINE_HI  = LINE_PERIOD + LINE_TOL;

    logic          sync_q;
    logic [CW-1:0] icnt;

    assign ow_rise     = iw_sync & ~sync_q;
    assign ow_interval = icnt;
    // A rise in the timeout cycle reloads icnt, so it suppresses the timeout.
    assign ow_timeout  = (icnt == CW'(TIMEOUT)) && !ow_rise;

    always_comb begin
        ow_class = CLS_BAD;
        if (32'(icnt) >= GAP_MIN)
            ow_class = CLS_GAP;
        else if ((32'(icnt) >= LINE_LO) && (32'(icnt) <= LINE_HI))
            ow_class = CLS_LINE;
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            sync_q <= 1'b0;
            icnt   <= '0;
        end else begin
            sync_q <= iw_sync;
            if (ow_rise)
                icnt <= CW'(1);
            else if (icnt != ICNT_MAX)
                icnt <= icnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_frame_lock_ctrl.sv
// Frame-lock sequencer for the LCD->VGA timing generator.
//   iw_clk         : LCD pixel clock (only clock)
//   iw_rst_n       : asynchronous active-low reset
//   iw_sync        : LCD composite sync
//   ow_tg_restart  : 1-cycle pulse after every frame-start (GAP) rise
//   ow_tg_enable   : high in LOCKED/HOLD
//   ow_locked      : high in LOCKED
//   ow_lock_lost   : 1-cycle pulse on LOCKED/HOLD -> SEARCH
//   ow_state       : 0 SEARCH, 1 VERIFY, 2 LOCKED, 3 HOLD
//   ow_line_period : interval of the last LINE rise
//   ow_frame_lines : line count of the last completed frame
module lcd_frame_lock_ctrl
    import lcd2vga_pkg::*;
#(
    parameter int unsigned CW              = 20,
    parameter int unsigned LINE_PERIOD     = VGA_H_TOTAL,
    parameter int unsigned LINE_TOL        = 4,
    parameter int unsigned GAP_MIN         = 1000,
    parameter int unsigned LINES_PER_FRAME = VGA_V_ACTIVE,
    parameter int unsigned LOCK_FRAMES     = 3,
    parameter int unsigned MISS_FRAMES     = 2,
    parameter int unsigned TIMEOUT         = 1048575
)(
    input  logic        iw_clk,
    input  logic        iw_rst_n,
    input  logic        iw_sync,
    output logic        ow_tg_restart,
    output logic        ow_tg_enable,
    output logic        ow_locked,
    output logic        ow_lock_lost,
    output logic [1:0]  ow_state,
    output logic [11:0] ow_line_period,
    output logic [9:0]  ow_frame_lines
);

    logic          rise;
    logic [CW-1:0] interval;
    ivl_class_t    ivl_class;
    logic          timeout;

    sync_interval_meter #(
        .CW          (CW),
        .LINE_PERIOD (LINE_PERIOD),
        .LINE_TOL    (LINE_TOL),
        .GAP_MIN     (GAP_MIN),
        .TIMEOUT     (TIMEOUT)
    ) u_meter (
        .iw_clk      (iw_clk),
        .iw_rst_n    (iw_rst_n),
        .iw_sync     (iw_sync),
        .ow_rise     (rise),
        .ow_interval (interval),
        .ow_class    (ivl_class),
        .ow_timeout  (timeout)
    );

    lock_state_t state, state_n;
    logic [7:0]  good_cnt, good_n;
    logic [7:0]  miss_cnt, miss_n;
    logic        lost_n;
    logic [9:0]  lcnt;
    logic        bad_seen;
    logic        gap_rise, line_rise, bad_rise, frame_good;

    assign gap_rise   = rise && (ivl_class == CLS_GAP);
    assign line_rise  = rise && (ivl_class == CLS_LINE);
    assign bad_rise   = rise && (ivl_class == CLS_BAD);
    assign frame_good = (lcnt == 10'(LINES_PER_FRAME)) && !bad_seen;
    assign ow_state   = state;

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        miss_n  = miss_cnt;
        lost_n  = 1'b0;
        if (timeout) begin
            state_n = ST_SEARCH;
            lost_n  = (state == ST_LOCKED) || (state == ST_HOLD);
        end else if (gap_rise) begin
            case (state)
                ST_SEARCH: begin
                    state_n = ST_VERIFY;
                    good_n  = '0;
                end
                ST_VERIFY: begin
                    if (frame_good) begin
                        good_n = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == 8'(LOCK_FRAMES)) begin
                            state_n = ST_LOCKED;
                            miss_n  = '0;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                ST_LOCKED: begin
                    if (frame_good) begin
                        miss_n = '0;
                    end else begin
                        miss_n = 8'd1;
                        if (MISS_FRAMES == 1) begin
                            state_n = ST_SEARCH;
                            lost_n  = 1'b1;
                        end else begin
                            state_n = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_good) begin
                        state_n = ST_LOCKED;
                        miss_n  = '0;
                    end else begin
                        miss_n = miss_cnt + 8'd1;
                        if (miss_cnt + 8'd1 == 8'(MISS_FRAMES)) begin
                            state_n = ST_SEARCH;
                            lost_n  = 1'b1;
                        end
                    end
                end
                default: state_n = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state          <= ST_SEARCH;
            good_cnt       <= '0;
            miss_cnt       <= '0;
            lcnt           <= '0;
            bad_seen       <= 1'b0;
            ow_tg_restart  <= 1'b0;
            ow_tg_enable   <= 1'b0;
            ow_locked      <= 1'b0;
            ow_lock_lost   <= 1'b0;
            ow_line_period <= '0;
            ow_frame_lines <= '0;
        end else begin
            state         <= state_n;
            good_cnt      <= good_n;
            miss_cnt      <= miss_n;
            ow_lock_lost  <= lost_n;
            ow_locked     <= (state_n == ST_LOCKED);
            ow_tg_enable  <= (state_n == ST_LOCKED) || (state_n == ST_HOLD);
            ow_tg_restart <= gap_rise;
            if (gap_rise) begin
                ow_frame_lines <= lcnt;
                lcnt           <= 10'd1;
                bad_seen       <= 1'b0;
            end else if (line_rise) begin
                if (lcnt != '1)
                    lcnt <= lcnt + 10'd1;
                ow_line_period <= 12'(interval);
            end else if (bad_rise) begin
                bad_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_lock_ctrl.sv
module tb_lcd_frame_lock_ctrl;

    localparam int LP    = 20;
    localparam int TOL   = 2;
    localparam int GMIN  = 60;
    localparam int LPF   = 8;
    localparam int TMO   = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        tg_restart, tg_enable, locked, lock_lost;
    logic [1:0]  state;
    logic [11:0] line_period;
    logic [9:0]  frame_lines;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_frame_lock_ctrl #(
        .CW              (12),
        .LINE_PERIOD     (LP),
        .LINE_TOL        (TOL),
        .GAP_MIN         (GMIN),
        .LINES_PER_FRAME (LPF),
        .LOCK_FRAMES     (3),
        .MISS_FRAMES     (2),
        .TIMEOUT         (TMO)
    ) dut (
        .iw_clk         (clk),
        .iw_rst_n       (rst_n),
        .iw_sync        (sync),
        .ow_tg_restart  (tg_restart),
        .ow_tg_enable   (tg_enable),
        .ow_locked      (locked),
        .ow_lock_lost   (lock_lost),
        .ow_state       (state),
        .ow_line_period (line_period),
        .ow_frame_lines (frame_lines)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("comparison %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    // One-cycle sync pulse; the rise is registered by the edge inside this task.
    task automatic rise_now();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    // Rest of a frame after its GAP rise: n rises in total (GAP included),
    // line intervals alternate per_a/per_b, rise index bad_at gets LP+TOL+1,
    // then a GAP_MIN-long gap so the next rise_now() is a GAP rise.
    task automatic lines(input int n, input int per_a, input int per_b, input int bad_at);
        for (int i = 1; i < n; i++) begin
            int per;
            if (i == bad_at)     per = LP + TOL + 1;
            else if (i % 2 == 1) per = per_a;
            else                 per = per_b;
            idle(per - 1);
            rise_now();
        end
        idle(GMIN - 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},  32'(state), 0);
        check({tag, "_enable"}, 32'(tg_enable), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_lost"},   32'(lock_lost), 0);
        check({tag, "_rst"},    32'(tg_restart), 0);
        check({tag, "_lper"},   32'(line_period), 0);
        check({tag, "_flines"}, 32'(frame_lines), 0);
    endtask

    initial begin
        int n_restart;
        int n_lost;
        int n_high;

        // Reset state
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal lock
        idle(GMIN);
        rise_now();
        check("nom_gap1_state", 32'(state), 1);
        check("nom_gap1_restart", 32'(tg_restart), 1);
        check("nom_gap1_enable", 32'(tg_enable), 0);
        lines(LPF, LP, LP, -1);
        check("nom_restart_low", 32'(tg_restart), 0);
        rise_now();
        check("nom_gap2_state", 32'(state), 1);
        lines(LPF, LP, LP, -1);
        rise_now();
        check("nom_gap3_state", 32'(state), 1);
        lines(LPF, LP, LP, -1);
        rise_now();
        check("nom_gap4_state", 32'(state), 2);
        check("nom_gap4_locked", 32'(locked), 1);
        check("nom_gap4_enable", 32'(tg_enable), 1);
        check("nom_gap4_restart", 32'(tg_restart), 1);
        check("nom_flines", 32'(frame_lines), LPF);
        check("nom_lper", 32'(line_period), LP);

        // Missed frames
        lines(LPF - 1, LP, LP, -1);
        rise_now();
        check("miss1_state", 32'(state), 3);
        check("miss1_enable", 32'(tg_enable), 1);
        check("miss1_locked", 32'(locked), 0);
        check("miss1_flines", 32'(frame_lines), LPF - 1);
        lines(LPF, LP, LP, -1);
        rise_now();
        check("miss_recover_state", 32'(state), 2);
        lines(LPF - 1, LP, LP, -1);
        rise_now();
        check("miss2_state", 32'(state), 3);
        check("miss2_lost", 32'(lock_lost), 0);
        lines(LPF - 1, LP, LP, -1);
        rise_now();
        check("miss3_state", 32'(state), 0);
        check("miss3_lost", 32'(lock_lost), 1);
        check("miss3_enable", 32'(tg_enable), 0);
        tick();
        check("miss3_lost_pulse", 32'(lock_lost), 0);

        // Jitter at the tolerance edges, one out-of-tolerance line in VERIFY
        lines(LPF, LP - TOL, LP + TOL, -1);
        rise_now();
        check("jit_gap1_state", 32'(state), 1);
        check("jit_lper_lo", 32'(line_period), LP - TOL);
        lines(LPF, LP - TOL, LP + TOL, -1);
        rise_now();
        check("jit_gap2_state", 32'(state), 1);
        lines(LPF, LP - TOL, LP + TOL, 3);
        rise_now();
        check("jit_bad_state", 32'(state), 1);
        check("jit_bad_flines", 32'(frame_lines), LPF - 1);
        lines(LPF, LP + TOL, LP - TOL, -1);
        rise_now();
        lines(LPF, LP + TOL, LP - TOL, -1);
        rise_now();
        check("jit_delayed_state", 32'(state), 1);
        lines(LPF, LP + TOL, LP - TOL, -1);
        rise_now();
        check("jit_lock_state", 32'(state), 2);
        check("jit_lper_hi", 32'(line_period), LP + TOL);

        // Timeout while locked
        idle(TMO - 2);
        check("tmo_before_state", 32'(state), 2);
        idle(1);
        check("tmo_at_state", 32'(state), 2);
        idle(1);
        check("tmo_state", 32'(state), 0);
        check("tmo_lost", 32'(lock_lost), 1);
        check("tmo_enable", 32'(tg_enable), 0);
        tick();
        check("tmo_lost_pulse", 32'(lock_lost), 0);

        // Relock, then a rise exactly on the timeout cycle
        rise_now();
        check("relock_gap1_state", 32'(state), 1);
        repeat (3) begin
            lines(LPF, LP, LP, -1);
            rise_now();
        end
        check("relock_state", 32'(state), 2);
        idle(TMO - 1);
        rise_now();
        check("race_state", 32'(state), 3);
        check("race_lost", 32'(lock_lost), 0);
        check("race_enable", 32'(tg_enable), 1);
        lines(LPF, LP, LP, -1);
        rise_now();
        check("race_recover_state", 32'(state), 2);

        // Asynchronous reset mid-LOCKED
        idle(5);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        idle(2);
        rst_n = 1'b1;
        idle(GMIN);
        rise_now();
        check("rst_gap1_state", 32'(state), 1);
        lines(LPF, LP, LP, -1);
        rise_now();
        lines(LPF, LP, LP, -1);
        rise_now();
        check("rst_gap3_state", 32'(state), 1);
        lines(LPF, LP, LP, -1);
        rise_now();
        check("rst_gap4_state", 32'(state), 2);

        // Stuck-high sync for two frame lengths
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(GMIN);
        sync = 1'b1;
        n_restart = 0;
        n_lost = 0;
        n_high = 0;
        for (int i = 0; i < 2 * (GMIN + (LPF - 1) * LP) + 40; i++) begin
            tick();
            if (i == 0) check("stuck_first_state", 32'(state), 1);
            if (tg_restart) n_restart++;
            if (lock_lost) n_lost++;
            if (state >= 2'd2) n_high++;
        end
        sync = 1'b0;
        check("stuck_restarts", 32'(n_restart), 1);
        check("stuck_lost", 32'(n_lost), 0);
        check("stuck_never_locked", 32'(n_high), 0);
        check("stuck_end_state", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
